pulse_shaping_interp_iq: RTL and testbench

Parametrised successor to the fixed single-channel 17-tap shaping FIR. It is a polyphase interpolating pulse-shaping filter for I and Q together, and accepts QPSK symbols through a valid/ready handshake. Each accepted symbol produces UPS shaped output samples per channel, one per clock. Coefficients load at run time through a write port, and outputs are rounded and saturated. It sits between the symbol mapper and the DAC interface.

---
 rtl/pulse_shaping_interp_iq.sv | 145 ++++++++++++++
 tb/tb_pulse_shaping_interp_iq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_shaping_interp_iq.sv
// rtl/pulse_shaping_interp_iq.sv - polyphase interpolating I/Q pulse-shaping FIR with runtime coefficients
module pulse_shaping_interp_iq #(
   parameter int UPS    = 4,
   parameter int TAPS   = 32,
   parameter int COEF_W = 16,
   parameter int OUT_W  = 14,
   parameter int SHIFT  = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sym_valid,
   output logic                       sym_ready,
   input  logic [1:0]                 sym_i,
   input  logic [1:0]                 sym_q,
   input  logic                       clear,
   input  logic                       coef_we,
   input  logic [$clog2(TAPS)-1:0]    coef_addr,
   input  logic signed [COEF_W-1:0]   coef_data,
   output logic                       out_valid,
   output logic signed [OUT_W-1:0]    out_i,
   output logic signed [OUT_W-1:0]    out_q
);

   localparam int PH     = TAPS / UPS;
   localparam int AW     = $clog2(TAPS);
   localparam int PW     = $clog2(UPS);
   localparam int ACC_W  = COEF_W + 3 + $clog2(PH);
   localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

   // Half-LSB of the shifted result, zero when no shift is applied
   localparam logic signed [ACC_W-1:0] RND    = (SHIFT > 0) ? (ACC_W'(1) << RND_SH) : '0;
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

   logic signed [COEF_W-1:0] r_coef [TAPS];
   logic signed [1:0]        r_xi   [PH];
   logic signed [1:0]        r_xq   [PH];
   logic [PW-1:0]            r_phase;
   logic                     r_active;
   logic                     r_out_valid;
   logic signed [OUT_W-1:0]  r_out_i;
   logic signed [OUT_W-1:0]  r_out_q;

   logic                     w_last;
   logic                     w_accept;
   logic signed [1:0]        w_sym_i;
   logic signed [1:0]        w_sym_q;
   logic signed [ACC_W-1:0]  w_acc_i;
   logic signed [ACC_W-1:0]  w_acc_q;

   // Sum of the coefficients of one polyphase branch weighted by ternary symbols
   function automatic logic signed [ACC_W-1:0] fir_sum(input logic signed [1:0] x [PH],
                                                       input logic [PW-1:0] ph);
      logic signed [ACC_W-1:0] acc;
      logic signed [ACC_W-1:0] c;
      acc = '0;
      for (int j = 0; j < PH; j++) begin
         c = ACC_W'(r_coef[AW'(j * UPS) + AW'(ph)]);
         if (x[j] == 2'b01)
            acc = acc + c;
         else if (x[j] == 2'b11)
            acc = acc - c;
      end
      return acc;
   endfunction

   // Round half up, arithmetic shift, then clip to the output range
   function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] r;
      r = (acc + RND) >>> SHIFT;
      if (r > SAT_HI)
         return SAT_HI[OUT_W-1:0];
      else if (r < SAT_LO)
         return SAT_LO[OUT_W-1:0];
      else
         return r[OUT_W-1:0];
   endfunction

   assign w_last    = (r_phase == PW'(UPS - 1));
   assign sym_ready = !r_active || w_last;
   assign w_accept  = sym_valid && sym_ready && !clear;
   // -2 has no QPSK meaning; fold it onto -1 so the datapath only sees -1/0/+1
   assign w_sym_i   = (sym_i == 2'b10) ? 2'sb11 : sym_i;
   assign w_sym_q   = (sym_q == 2'b10) ? 2'sb11 : sym_q;
   assign w_acc_i   = fir_sum(r_xi, r_phase);
   assign w_acc_q   = fir_sum(r_xq, r_phase);

   assign out_valid = r_out_valid;
   assign out_i     = r_out_i;
   assign out_q     = r_out_q;

   // Symbol acceptance, phase sequencing and delay lines (held, not zero-stuffed, when starved)
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         r_active <= 1'b0;
         r_phase  <= '0;
         for (int j = 0; j < PH; j++) begin
            r_xi[j] <= '0;
            r_xq[j] <= '0;
         end
      end else if (w_accept) begin
         for (int j = PH - 1; j > 0; j--) begin
            r_xi[j] <= r_xi[j-1];
            r_xq[j] <= r_xq[j-1];
         end
         r_xi[0]  <= w_sym_i;
         r_xq[0]  <= w_sym_q;
         r_phase  <= '0;
         r_active <= 1'b1;
      end else if (r_active) begin
         if (w_last)
            r_active <= 1'b0;
         else
            r_phase <= r_phase + 1'b1;
      end
   end

   // Coefficient bank: writable only while idle, survives clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++)
            r_coef[k] <= '0;
      end else if (coef_we && !r_active && (32'(coef_addr) < 32'(TAPS))) begin
         r_coef[coef_addr] <= coef_data;
      end
   end

   // Output register: one shaped sample per active cycle, data held when idle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_i     <= '0;
         r_out_q     <= '0;
      end else if (clear) begin
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= r_active;
         if (r_active) begin
            r_out_i <= round_sat(w_acc_i);
            r_out_q <= round_sat(w_acc_q);
         end
      end
   end

endmodule

// File: tb/tb_pulse_shaping_interp_iq.sv
// tb/tb_pulse_shaping_interp_iq.sv - directed bench for pulse_shaping_interp_iq (two parameter sets)
module tb_pulse_shaping_interp_iq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n, sym_valid, clear, coef_we;
   logic [1:0]         sym_i, sym_q;
   logic [3:0]         coef_addr;
   logic signed [15:0] coef_data;

   logic               a_ready, a_valid, b_ready, b_valid;
   logic signed [7:0]  a_i, a_q;
   logic signed [13:0] b_i, b_q;

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0] si [4];
   logic [1:0] sq [4];
   int ea [16];
   int eq [16];
   int eb [16];

   // A: no shift, 8-bit output (saturation); B: shift 2, 14-bit output (rounding)
   pulse_shaping_interp_iq #(.UPS(4), .TAPS(16), .COEF_W(16), .OUT_W(8), .SHIFT(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_ready(a_ready),
      .sym_i(sym_i), .sym_q(sym_q), .clear(clear), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(a_valid), .out_i(a_i), .out_q(a_q));

   pulse_shaping_interp_iq #(.UPS(4), .TAPS(16), .COEF_W(16), .OUT_W(14), .SHIFT(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_ready(b_ready),
      .sym_i(sym_i), .sym_q(sym_q), .clear(clear), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(b_valid), .out_i(b_i), .out_q(b_q));

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int rnd2(input int v);
      return (v + 2) >>> 2;
   endfunction

   task automatic wr(input int k, input int v);
      coef_we   = 1'b1;
      coef_addr = 4'(k);
      coef_data = 16'(v);
      tick;
      coef_we   = 1'b0;
   endtask

   task automatic do_clear;
      clear = 1'b1;
      tick;
      clear = 1'b0;
   endtask

   task automatic send1(input logic [1:0] vi, input logic [1:0] vq);
      sym_valid = 1'b1;
      sym_i     = vi;
      sym_q     = vq;
      tick;
      sym_valid = 1'b0;
   endtask

   task automatic chk_out(input string tag, input int exp_a_i, input int exp_a_q, input int exp_b_i);
      chk({tag, "_va"}, int'(a_valid), 1);
      chk({tag, "_ai"}, int'(a_i), exp_a_i);
      chk({tag, "_aq"}, int'(a_q), exp_a_q);
      chk({tag, "_bi"}, int'(b_i), exp_b_i);
   endtask

   // Four symbols back to back, then starvation; expected arrays indexed by output sample
   task automatic burst4(input string tag);
      chk({tag, "_rdy0"}, int'(a_ready), 1);
      sym_valid = 1'b1;
      sym_i = si[0];
      sym_q = sq[0];
      tick;
      chk({tag, "_lat"}, int'(a_valid), 0);
      sym_i = si[1];
      sym_q = sq[1];
      for (int t = 1; t <= 16; t++) begin
         tick;
         chk_out(tag, ea[t-1], eq[t-1], eb[t-1]);
         chk({tag, "_rdy"}, int'(a_ready), ((t % 4) == 3 || t == 16) ? 1 : 0);
         if (t == 4) begin
            sym_i = si[2];
            sym_q = sq[2];
         end else if (t == 8) begin
            sym_i = si[3];
            sym_q = sq[3];
         end else if (t == 12) begin
            sym_valid = 1'b0;
         end
      end
      tick;
      chk({tag, "_end"}, int'(a_valid), 0);
   endtask

   initial begin
      rst_n = 1'b0; sym_valid = 1'b0; clear = 1'b0; coef_we = 1'b0;
      sym_i = 2'b00; sym_q = 2'b00; coef_addr = '0; coef_data = '0;
      tick;
      tick;
      rst_n = 1'b1;

      // reset state
      chk("rst_valid", int'(a_valid), 0);
      chk("rst_i", int'(a_i), 0);
      chk("rst_q", int'(a_q), 0);
      chk("rst_ready", int'(a_ready), 1);
      chk("rst_b_ready", int'(b_ready), 1);
      chk("rst_b_valid", int'(b_valid), 0);

      // impulse response h[k]=k+1 read back through the polyphase sequence
      for (int k = 0; k < 16; k++) wr(k, k + 1);
      si = '{2'b01, 2'b00, 2'b00, 2'b00};
      sq = '{2'b11, 2'b00, 2'b00, 2'b00};
      for (int t = 0; t < 16; t++) begin
         ea[t] = t + 1;
         eq[t] = -(t + 1);
         eb[t] = rnd2(t + 1);
      end
      burst4("main");
      chk("main_hold", int'(a_i), 16);

      // handshake gap of three cycles, clamped -2 symbol afterwards
      do_clear;
      chk("hs_clr", int'(a_valid), 0);
      send1(2'b01, 2'b11);
      for (int p = 0; p < 4; p++) begin
         tick;
         chk_out("hs_a", p + 1, -(p + 1), rnd2(p + 1));
      end
      tick;
      chk("hs_gap0_v", int'(a_valid), 0);
      chk("hs_gap0_r", int'(a_ready), 1);
      tick;
      chk("hs_gap1_v", int'(a_valid), 0);
      chk("hs_gap1_r", int'(a_ready), 1);
      sym_valid = 1'b1;
      sym_i = 2'b10;
      sym_q = 2'b01;
      tick;
      sym_valid = 1'b0;
      chk("hs_gap2_v", int'(a_valid), 0);
      for (int p = 0; p < 4; p++) begin
         tick;
         chk_out("hs_b", 4, -4, 1);
      end
      tick;
      chk("hs_end", int'(a_valid), 0);

      // coefficient write while active is dropped
      do_clear;
      send1(2'b01, 2'b00);
      coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'sd99;
      for (int p = 0; p < 4; p++) begin
         tick;
         chk_out("cw_act", p + 1, 0, rnd2(p + 1));
      end
      coef_we = 1'b0;
      // write and accept on the same idle edge: new h[4] used from phase 0
      coef_we = 1'b1; coef_addr = 4'd4; coef_data = 16'sd50;
      send1(2'b00, 2'b00);
      coef_we = 1'b0;
      tick;
      chk_out("cw_same", 50, 0, rnd2(50));
      for (int p = 1; p < 4; p++) begin
         tick;
         chk_out("cw_same", p + 5, 0, rnd2(p + 5));
      end
      do_clear;
      send1(2'b01, 2'b00);
      tick;
      chk("cw_h0_kept", int'(a_i), 1);
      tick; tick; tick;
      wr(4, 5);

      // rounding on B (shift 2), exact on A
      do_clear;
      wr(0, 6);
      send1(2'b01, 2'b11);
      tick;
      chk_out("rnd_p6", 6, -6, 2);
      chk("rnd_q_m6", int'(b_q), -1);
      tick; tick; tick;
      do_clear;
      wr(0, -6);
      send1(2'b01, 2'b00);
      tick;
      chk_out("rnd_m6", -6, 0, -1);
      tick; tick; tick;
      do_clear;
      wr(0, 5);
      send1(2'b01, 2'b00);
      tick;
      chk_out("rnd_p5", 5, 0, 1);
      tick; tick; tick;

      // saturation on A: all taps 100
      for (int k = 0; k < 16; k++) wr(k, 100);
      do_clear;
      si = '{2'b01, 2'b01, 2'b01, 2'b01};
      sq = '{2'b11, 2'b11, 2'b11, 2'b11};
      for (int t = 0; t < 16; t++) begin
         ea[t] = (t < 4) ? 100 : 127;
         eq[t] = (t < 4) ? -100 : -128;
         eb[t] = rnd2(100 * (t / 4 + 1));
      end
      burst4("satp");
      do_clear;
      si = '{2'b10, 2'b10, 2'b10, 2'b10};
      sq = '{2'b00, 2'b00, 2'b00, 2'b00};
      for (int t = 0; t < 16; t++) begin
         ea[t] = (t < 4) ? -100 : -128;
         eq[t] = 0;
         eb[t] = rnd2(-100 * (t / 4 + 1));
      end
      burst4("satn");

      // reset mid-burst clears coefficients and aborts output
      for (int k = 0; k < 16; k++) wr(k, k + 1);
      do_clear;
      send1(2'b01, 2'b11);
      tick;
      chk_out("mr_pre", 1, -1, 0);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("mr_valid", int'(a_valid), 0);
      chk("mr_i", int'(a_i), 0);
      chk("mr_ready", int'(a_ready), 1);
      tick;
      chk("mr_valid2", int'(a_valid), 0);
      send1(2'b01, 2'b11);
      tick;
      chk_out("mr_zero", 0, 0, 0);
      tick; tick; tick;

      // clear mid-burst beats a simultaneous accept, keeps coefficients
      for (int k = 0; k < 16; k++) wr(k, k + 1);
      do_clear;
      send1(2'b01, 2'b11);
      tick;
      chk_out("mc_pre", 1, -1, 0);
      tick; tick;
      clear = 1'b1;
      sym_valid = 1'b1;
      sym_i = 2'b11;
      sym_q = 2'b01;
      chk("mc_ready_pre", int'(a_ready), 1);
      tick;
      clear = 1'b0;
      sym_valid = 1'b0;
      chk("mc_valid", int'(a_valid), 0);
      chk("mc_ready", int'(a_ready), 1);
      tick;
      chk("mc_valid2", int'(a_valid), 0);
      send1(2'b00, 2'b00);
      tick;
      chk_out("mc_hist0", 0, 0, 0);
      tick; tick; tick;
      send1(2'b01, 2'b00);
      tick;
      chk_out("mc_coef", 1, 0, 0);
      tick; tick; tick;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
